// File: rtl/auth_msg_serializer_pkg.sv
// Shared constants, state encoding and CRC-8 helper for the auth message serializer.
// The CRC state only exists when AUTH_SERIALIZER_CRC_EN is defined.
`timescale 1ns/1ps
package auth_msg_serializer_pkg;

  localparam int MSG_LEN                 = 256;
  localparam int SIZE_OF_HEADER_VARS     = 32;
  localparam int SIZE_OF_HEADER_IN_BYTES = SIZE_OF_HEADER_VARS / 8;
  localparam int MSG_LEN_BYTES           = MSG_LEN / 8;
  localparam logic [7:0] CRC8_POLY       = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
`ifdef AUTH_SERIALIZER_CRC_EN
    ST_CRC  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

  // MSB-first CRC-8 update of one byte, init handled by the caller.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/auth_msg_serializer_crc8_byte_step.sv
// Combinational next-CRC from the running CRC-8 and one message byte.
`timescale 1ns/1ps
module crc8_byte_step
  import auth_msg_serializer_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_step(crc_in, data_in);

endmodule

// File: rtl/auth_msg_serializer.sv
// Serializes a captured header+payload response MSB-byte-first over a valid/ready byte stream.
// Define AUTH_SERIALIZER_CRC_EN to append a CRC-8 byte after the payload.
`timescale 1ns/1ps
module auth_msg_serializer
  import auth_msg_serializer_pkg::*;
#(
  parameter int HDR_BYTES = SIZE_OF_HEADER_IN_BYTES,
  parameter int MSG_BYTES = MSG_LEN_BYTES
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [8*HDR_BYTES-1:0]             header,
  input  logic [8*(MSG_BYTES-HDR_BYTES)-1:0] payload,
  input  logic                               Ack_in,
  input  logic                               Error_in,
  input  logic                               tx_ready,
  output logic [7:0]                         tx_byte,
  output logic                               tx_valid,
  output logic                               tx_last,
  output logic                               busy,
  output logic                               done,
  output logic                               err_pulse,
  output logic                               overrun
);

  localparam int         MSG_W    = 8 * MSG_BYTES;
  localparam logic [5:0] HDR_LAST = 6'(HDR_BYTES - 1);
  localparam logic [5:0] PAY_LAST = 6'(MSG_BYTES - HDR_BYTES - 1);
`ifndef AUTH_SERIALIZER_CRC_EN
  localparam logic [5:0] PAY_PRELAST = 6'(MSG_BYTES - HDR_BYTES - 2);
`endif

  state_t           state_r;
  logic [5:0]       cnt_r;
  logic [MSG_W-1:0] buf_r;
  logic             ack_q_r;
  logic             err_q_r;
  logic             ack_rise_s;
  logic             err_rise_s;
  logic             hs_s;
  logic [MSG_W-1:0] msg_s;
  logic [7:0]       next_byte_s;

  assign ack_rise_s  = Ack_in & ~ack_q_r;
  assign err_rise_s  = Error_in & ~err_q_r;
  assign hs_s        = tx_valid & tx_ready;
  assign msg_s       = {header, payload};
  assign next_byte_s = buf_r[MSG_W-1 -: 8];

`ifdef AUTH_SERIALIZER_CRC_EN
  logic [7:0] crc_r;
  logic [7:0] crc_next_s;

  crc8_byte_step u_crc8_byte_step (
    .crc_in  (crc_r),
    .data_in (tx_byte),
    .crc_out (crc_next_s)
  );
`endif

  // Message sequencer: edge detect, capture, byte shifting and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      buf_r     <= '0;
      ack_q_r   <= 1'b0;
      err_q_r   <= 1'b0;
      tx_byte   <= 8'h00;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_pulse <= 1'b0;
      overrun   <= 1'b0;
`ifdef AUTH_SERIALIZER_CRC_EN
      crc_r     <= 8'h00;
`endif
    end else begin
      ack_q_r   <= Ack_in;
      err_q_r   <= Error_in;
      done      <= 1'b0;
      err_pulse <= 1'b0;
      overrun   <= (state_r != ST_IDLE) && ack_rise_s;
      case (state_r)
        ST_IDLE: begin
          // Simultaneous Ack/Error edges are an error, never a start.
          if (err_rise_s) begin
            err_pulse <= 1'b1;
          end else if (ack_rise_s) begin
            buf_r    <= {msg_s[MSG_W-9:0], 8'h00};
            tx_byte  <= msg_s[MSG_W-1 -: 8];
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            busy     <= 1'b1;
            cnt_r    <= 6'd0;
            state_r  <= ST_HDR;
`ifdef AUTH_SERIALIZER_CRC_EN
            crc_r    <= 8'h00;
`endif
          end
        end
        ST_HDR: begin
          if (hs_s) begin
            tx_byte <= next_byte_s;
            buf_r   <= {buf_r[MSG_W-9:0], 8'h00};
`ifdef AUTH_SERIALIZER_CRC_EN
            crc_r   <= crc_next_s;
`endif
            if (cnt_r == HDR_LAST) begin
              cnt_r   <= 6'd0;
              state_r <= ST_PAY;
`ifndef AUTH_SERIALIZER_CRC_EN
              tx_last <= (PAY_LAST == 6'd0);
`endif
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        ST_PAY: begin
          if (hs_s) begin
`ifdef AUTH_SERIALIZER_CRC_EN
            crc_r <= crc_next_s;
`endif
            if (cnt_r == PAY_LAST) begin
              cnt_r <= 6'd0;
`ifdef AUTH_SERIALIZER_CRC_EN
              // The CRC already covers the byte handed off in this cycle.
              tx_byte <= crc_next_s;
              tx_last <= 1'b1;
              state_r <= ST_CRC;
`else
              tx_byte  <= 8'h00;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state_r  <= ST_DONE;
`endif
            end else begin
              cnt_r   <= cnt_r + 6'd1;
              tx_byte <= next_byte_s;
              buf_r   <= {buf_r[MSG_W-9:0], 8'h00};
`ifndef AUTH_SERIALIZER_CRC_EN
              tx_last <= (cnt_r == PAY_PRELAST);
`endif
            end
          end
        end
`ifdef AUTH_SERIALIZER_CRC_EN
        ST_CRC: begin
          if (hs_s) begin
            tx_byte  <= 8'h00;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_msg_serializer.sv
// Directed self-checking bench for auth_msg_serializer (CRC checks follow AUTH_SERIALIZER_CRC_EN).
`timescale 1ns/1ps
module tb_auth_msg_serializer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  header = 32'h0;
  logic [223:0] payload = 224'h0;
  logic         Ack_in = 1'b0;
  logic         Error_in = 1'b0;
  logic         tx_ready = 1'b1;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_last;
  logic         busy;
  logic         done;
  logic         err_pulse;
  logic         overrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] exp_msg;
  logic [7:0]   got [0:63];

`ifdef AUTH_SERIALIZER_CRC_EN
  localparam int N_BYTES = 33;
  localparam int DONE_FAST = 34;
  localparam int DONE_SLOW = 66;
`else
  localparam int N_BYTES = 32;
  localparam int DONE_FAST = 33;
  localparam int DONE_SLOW = 64;
`endif

  auth_msg_serializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .header    (header),
    .payload   (payload),
    .Ack_in    (Ack_in),
    .Error_in  (Error_in),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .busy      (busy),
    .done      (done),
    .err_pulse (err_pulse),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Bit-serial CRC-8 reference (poly 0x07, init 0, MSB first).
  function automatic logic [7:0] crc_ref(input logic [255:0] m);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 255; i >= 0; i--) begin
      fb = c[7] ^ m[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    if (k < 32) return exp_msg[255 - 8*k -: 8];
    else        return crc_ref(exp_msg);
  endfunction

  task automatic start_msg();
    @(negedge clk);
    header  = exp_msg[255:224];
    payload = exp_msg[223:0];
    Ack_in  = 1'b1;
  endtask

  // Observes one message from negedges; scrambles inputs to show they were captured.
  task automatic collect(input int mode, input int ovr_at,
                         output int nbytes, output int done_at, output int last_pos,
                         output int last_cnt, output int stall_bad, output int ovr_cnt,
                         output int busy_bad);
    logic [7:0] pb;
    logic       pl;
    logic       pstall;
    bit         fired;
    nbytes = 0; done_at = 0; last_pos = -1; last_cnt = 0;
    stall_bad = 0; ovr_cnt = 0; busy_bad = 0;
    pb = 8'h00; pl = 1'b0; pstall = 1'b0; fired = 1'b0;
    for (int i = 0; i < 64; i++) got[i] = 8'hxx;
    for (int c = 1; c <= 200 && done_at == 0; c++) begin
      @(negedge clk);
      Ack_in  = 1'b0;
      header  = $urandom;
      payload = {7{$urandom}};
      if (ovr_at >= 0 && nbytes == ovr_at && !fired) begin
        Ack_in = 1'b1;
        fired  = 1'b1;
      end
      if (overrun) ovr_cnt++;
      if (done) begin
        done_at = c;
      end else begin
        if (pstall && (tx_byte !== pb || tx_last !== pl || tx_valid !== 1'b1)) stall_bad++;
        if (tx_valid && !busy) busy_bad++;
        tx_ready = (mode == 0) ? 1'b1 : c[0];
        pstall = tx_valid && !tx_ready;
        pb = tx_byte;
        pl = tx_last;
        if (tx_valid && tx_ready && nbytes < 64) begin
          got[nbytes] = tx_byte;
          if (tx_last) begin
            last_pos = nbytes;
            last_cnt++;
          end
          nbytes++;
        end
      end
    end
    Ack_in   = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({tx_valid, tx_last, busy, done, err_pulse, overrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000000", {tx_valid, tx_last, busy, done, err_pulse, overrun});
    end
    tests_run++;
    if (tx_byte !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_byte: got %h expected 00", tx_byte);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_valid: got %b expected 0", tx_valid);
    end
  endtask

  task automatic test_stream(input int mode, input int exp_done);
    int nb, da, lp, lc, sb, oc, bb;
    start_msg();
    collect(mode, -1, nb, da, lp, lc, sb, oc, bb);
    tests_run++;
    if (nb !== N_BYTES) begin
      tests_failed++;
      $display("FAIL stream%0d_count: got %0d expected %0d", mode, nb, N_BYTES);
    end
    for (int i = 0; i < N_BYTES; i++) begin
      tests_run++;
      if (got[i] !== exp_byte(i)) begin
        tests_failed++;
        $display("FAIL stream%0d_byte%0d: got %h expected %h", mode, i, got[i], exp_byte(i));
      end
    end
    tests_run++;
    if (lp !== N_BYTES - 1 || lc !== 1) begin
      tests_failed++;
      $display("FAIL stream%0d_last: got pos %0d cnt %0d expected pos %0d cnt 1", mode, lp, lc, N_BYTES - 1);
    end
    tests_run++;
    if (da !== exp_done) begin
      tests_failed++;
      $display("FAIL stream%0d_done_cycle: got %0d expected %0d", mode, da, exp_done);
    end
    tests_run++;
    if (sb !== 0 || bb !== 0 || oc !== 0) begin
      tests_failed++;
      $display("FAIL stream%0d_stall_busy: got stall %0d busy %0d ovr %0d expected 0 0 0", mode, sb, bb, oc);
    end
    tests_run++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream%0d_done_busy: got busy %b valid %b expected 0 0", mode, busy, tx_valid);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream%0d_done_pulse: got %b expected 0", mode, done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_error();
    int any_valid;
    @(negedge clk);
    Ack_in = 1'b1;
    Error_in = 1'b1;
    @(negedge clk);
    tests_run++;
    if (err_pulse !== 1'b1 || tx_valid !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_pulse: got err %b valid %b ovr %b expected 1 0 0", err_pulse, tx_valid, overrun);
    end
    @(negedge clk);
    Error_in = 1'b0;
    tests_run++;
    if (err_pulse !== 1'b0 || tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_one_cycle: got err %b valid %b expected 0 0", err_pulse, tx_valid);
    end
    any_valid = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || busy !== 1'b0) any_valid++;
    end
    tests_run++;
    if (any_valid !== 0) begin
      tests_failed++;
      $display("FAIL ack_level_no_start: got %0d active cycles expected 0", any_valid);
    end
    Ack_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun();
    int nb, da, lp, lc, sb, oc, bb, bad;
    start_msg();
    collect(0, 10, nb, da, lp, lc, sb, oc, bb);
    tests_run++;
    if (oc !== 1) begin
      tests_failed++;
      $display("FAIL overrun_pulses: got %0d expected 1", oc);
    end
    bad = 0;
    for (int i = 0; i < N_BYTES; i++) if (got[i] !== exp_byte(i)) bad++;
    tests_run++;
    if (nb !== N_BYTES || bad !== 0 || da !== DONE_FAST) begin
      tests_failed++;
      $display("FAIL overrun_msg: got %0d bytes %0d wrong done %0d expected %0d 0 %0d", nb, bad, da, N_BYTES, DONE_FAST);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_no_restart: got valid %b expected 0", tx_valid);
    end
  endtask

  task automatic test_async_reset();
    int active, nb, da, lp, lc, sb, oc, bb;
    start_msg();
    @(negedge clk);
    Ack_in = 1'b0;
    repeat (15) @(negedge clk);
    tests_run++;
    if (tx_byte !== exp_byte(15) || tx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: got %h valid %b expected %h 1", tx_byte, tx_valid, exp_byte(15));
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({tx_valid, tx_last, busy, done, err_pulse, overrun} !== 6'b0 || tx_byte !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_async: got flags %b byte %h expected 000000 00",
               {tx_valid, tx_last, busy, done, err_pulse, overrun}, tx_byte);
    end
    @(negedge clk);
    reset_n = 1'b1;
    active = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || busy !== 1'b0) active++;
    end
    tests_run++;
    if (active !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_resume: got %0d active cycles expected 0", active);
    end
    start_msg();
    collect(0, -1, nb, da, lp, lc, sb, oc, bb);
    tests_run++;
    if (nb !== N_BYTES || got[0] !== exp_byte(0) || got[N_BYTES-1] !== exp_byte(N_BYTES-1)) begin
      tests_failed++;
      $display("FAIL midreset_restart: got %0d bytes first %h last %h expected %0d %h %h",
               nb, got[0], got[N_BYTES-1], N_BYTES, exp_byte(0), exp_byte(N_BYTES-1));
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef AUTH_SERIALIZER_CRC_EN
  task automatic test_crc();
    int nb, da, lp, lc, sb, oc, bb;
    exp_msg = 256'h0;
    start_msg();
    collect(0, -1, nb, da, lp, lc, sb, oc, bb);
    tests_run++;
    if (nb !== 33 || got[32] !== 8'h00 || lp !== 32) begin
      tests_failed++;
      $display("FAIL crc_zero: got %0d bytes crc %h lastpos %0d expected 33 00 32", nb, got[32], lp);
    end
    repeat (2) @(negedge clk);
    exp_msg = {32'h00000001, 224'h0};
    start_msg();
    collect(0, -1, nb, da, lp, lc, sb, oc, bb);
    tests_run++;
    if (nb !== 33 || got[32] !== crc_ref(exp_msg) || lp !== 32) begin
      tests_failed++;
      $display("FAIL crc_one: got %0d bytes crc %h lastpos %0d expected 33 %h 32", nb, got[32], lp, crc_ref(exp_msg));
    end
  endtask
`endif

  initial begin
    exp_msg[255:224] = 32'h10030001;
    for (int i = 0; i < 27; i++) exp_msg[223 - 8*i -: 8] = 8'h10 + 8'(i);
    exp_msg[7:0] = 8'hAB;
    test_reset();
    test_stream(0, DONE_FAST);
    test_stream(1, DONE_SLOW);
    test_error();
    test_overrun();
    test_async_reset();
`ifdef AUTH_SERIALIZER_CRC_EN
    test_crc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/auth_msg_serializer.md
AUTH_MSG_SERIALIZER -- requirements
Module: auth_msg_serializer

Interface
REQ-001 Parameter HDR_BYTES, default 4, SHALL be the header length in bytes (`SIZE_OF_HEADER_IN_BYTES).
REQ-002 Parameter MSG_BYTES, default 32, SHALL be the total message length in bytes (`MSG_LEN/8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 header  input  8*HDR_BYTES  SHALL carry the response header from the challenge answer stage.
REQ-006 payload  input  8*(MSG_BYTES-HDR_BYTES)  SHALL carry the response payload.
REQ-007 Ack_in  input  1  SHALL be the "message ready" level from the upstream stage.
REQ-008 Error_in  input  1  SHALL be the upstream invalid-request flag.
REQ-009 tx_ready  input  1  SHALL be the downstream byte acceptance.
REQ-010 tx_byte  output  8  SHALL be the current byte.
REQ-011 tx_valid  output  1  SHALL mark tx_byte valid.
REQ-012 tx_last  output  1  SHALL mark the final byte of a message.
REQ-013 busy  output  1  SHALL be high from capture until the final handshake.
REQ-014 done  output  1  SHALL be a one-cycle pulse after the final handshake.
REQ-015 err_pulse  output  1  SHALL be a one-cycle pulse on a detected upstream error.
REQ-016 overrun  output  1  SHALL be a one-cycle pulse when a new Ack_in rising edge arrives while busy.

Function
REQ-017 Start SHALL be the rising edge of Ack_in (registered previous value); a level alone SHALL NOT start a second message.
REQ-018 On start in IDLE, header and payload SHALL be captured into an internal shift buffer in the same cycle; later input changes SHALL NOT affect the message.
REQ-019 States SHALL be IDLE, HDR, PAY, CRC, DONE; IDLE->HDR on start, HDR->PAY after HDR_BYTES handshakes, PAY->CRC (or DONE without CRC) after MSG_BYTES-HDR_BYTES handshakes, CRC->DONE after one handshake, DONE->IDLE unconditionally after one cycle.
REQ-020 Byte order SHALL be most-significant byte first: header[31:24] first, payload LSB byte last.
REQ-021 A handshake SHALL occur when tx_valid and tx_ready are both high; the byte counter SHALL advance only on a handshake.
REQ-022 tx_byte, tx_last SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-023 tx_valid SHALL rise the cycle after start (latency 1) and SHALL stay high until the last handshake, with back-to-back bytes when tx_ready is held high (MSG_BYTES cycles per message).
REQ-024 tx_last SHALL be high only with the final byte (last payload byte, or the CRC byte when enabled).
REQ-025 Byte counter SHALL be 6 bits wide, SHALL reset to 0 on each state entry, and SHALL never wrap.
REQ-026 Error_in rising edge in IDLE SHALL raise err_pulse for one cycle and SHALL NOT start a message; Ack_in and Error_in rising in the same cycle SHALL be treated as error only.
REQ-027 Ack_in rising edge outside IDLE SHALL pulse overrun and SHALL be dropped; the message in progress SHALL continue unchanged.
REQ-028 done SHALL pulse in the DONE state; busy SHALL be low in IDLE and DONE.

Reset
REQ-029 Asserting reset_n low SHALL immediately force IDLE, counters 0, buffer 0, Ack/Error edge registers 0, and all outputs 0, including in the middle of a message; no partial message SHALL resume after release.

Configuration
REQ-030 With AUTH_SERIALIZER_CRC_EN defined, a CRC-8 (polynomial 0x07, init 0x00, MSB first) over all MSG_BYTES bytes SHALL be sent as byte MSG_BYTES+1 with tx_last.
REQ-031 Without AUTH_SERIALIZER_CRC_EN, the CRC state and logic SHALL be absent and tx_last SHALL accompany the last payload byte.

Structure
REQ-032 Parameters.v SHALL hold MSG_LEN, SIZE_OF_HEADER_VARS, SIZE_OF_HEADER_IN_BYTES, the new MSG_LEN_BYTES, CRC8_POLY and the state encodings.
REQ-033 One sub-module, crc8_byte_step (combinational next-CRC from CRC and byte), SHALL be instantiated only under AUTH_SERIALIZER_CRC_EN.

Verification
REQ-034 header=32'h10030001, payload=224'h1010...AB, tx_ready=1, Ack_in pulse -> 32 back-to-back bytes 10,03,00,01,10,...,AB; tx_last on byte 32; done one cycle later.
REQ-035 Same message, tx_ready toggling 1/0 -> identical byte sequence, bytes held stable during stalls, 64 cycles to done.
REQ-036 Error_in rises with Ack_in -> err_pulse=1 for one cycle, tx_valid stays 0.
REQ-037 Second Ack_in rising edge at byte 10 -> overrun pulse, original 32 bytes complete unchanged.
REQ-038 reset_n low at byte 15 -> all outputs 0 asynchronously; after release tx_valid stays 0 until a new Ack_in edge.
REQ-039 AUTH_SERIALIZER_CRC_EN defined, all-zero message -> 33 bytes, final CRC byte 8'h00 with tx_last; message 32'h00000001 header, zero payload -> CRC byte matches reference model.
